// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with stall timeout and error pulse.
// Define WB_ARB_RR_EN to resolve simultaneous requests round-robin (default: master 0 wins).
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_gnt;
    logic [1:0]         r_err;
    logic [CNT_W-1:0]   r_cnt;
`ifdef WB_ARB_RR_EN
    logic               r_last;
`endif

    logic w_sel0;
    logic w_sel1;
    logic w_pick1;
    logic w_timeout;

    // Arbitration decision used only while idle
    always_comb begin
`ifdef WB_ARB_RR_EN
        w_pick1 = m1_cyc_i && (!m0_cyc_i || !r_last);
`else
        w_pick1 = m1_cyc_i && !m0_cyc_i;
`endif
    end

    assign w_sel0    = (r_state == GNT0);
    assign w_sel1    = (r_state == GNT1);
    // An ack arriving in the expiry cycle completes the access instead of timing out
    assign w_timeout = (w_sel0 || w_sel1) && (r_cnt == CNT_W'(TIMEOUT_CYC)) && !s_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_err   <= 2'b00;
            r_cnt   <= '0;
`ifdef WB_ARB_RR_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_err <= 2'b00;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (m0_cyc_i || m1_cyc_i) begin
                        r_state <= w_pick1 ? GNT1 : GNT0;
                        r_gnt   <= w_pick1 ? 2'b10 : 2'b01;
`ifdef WB_ARB_RR_EN
                        r_last  <= w_pick1;
`endif
                    end
                end
                GNT0, GNT1: begin
                    if (w_timeout || !s_cyc_o) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                        r_cnt   <= '0;
                        if (w_timeout) r_err <= r_gnt;
                    end else if (s_ack_i) begin
                        r_cnt <= '0;
                    end else if (s_stb_o) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Slave-side mux of the granted master; all zero while idle
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_addr_o = 32'h0;
        s_data_o = 32'h0;
        if (w_sel0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (w_sel1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end
    end

    assign m0_ack_o  = w_sel0 && s_ack_i;
    assign m1_ack_o  = w_sel1 && s_ack_i;
    assign m0_data_o = (w_sel0 && s_ack_i) ? s_data_i : 32'h0;
    assign m1_data_o = (w_sel1 && s_ack_i) ? s_data_i : 32'h0;
    assign m0_err_o  = r_err[0];
    assign m1_err_o  = r_err[1];
    assign gnt_o     = r_gnt;

endmodule
